// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data; data has priority with IF anti-starvation.
// Latency: mem_req_o one cycle after IDLE sample, ready one cycle after ack; requesters hold req until ready (stall_o).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic              stall_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_I  = 3'd1,
        MEM_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              if_wins;

    // IF only beats a concurrent data request once it has been passed over STARVE_MAX times.
    assign if_wins = if_req_i && (!d_req_i || (starve_cnt_q == STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (if_wins) begin
                    state_d      = MEM_I;
                    addr_d       = if_addr_i;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    wd_cnt_d     = '0;
                    starve_cnt_d = '0;
                end else if (d_req_i) begin
                    state_d  = MEM_D;
                    addr_d   = d_addr_i;
                    we_d     = d_we_i;
                    wdata_d  = d_wdata_i;
                    wd_cnt_d = '0;
                    if (if_req_i && (starve_cnt_q < STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            MEM_I: begin
                if (mem_ack_i) begin
                    state_d    = RESP_I;
                    if_rdata_d = mem_rdata_i;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d    = RESP_I;
                    if_rdata_d = '0;
                    err_d      = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            MEM_D: begin
                if (mem_ack_i) begin
                    state_d = RESP_D;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d = RESP_D;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = '0;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            RESP_I, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wd_cnt_q     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    // Request and ready decode straight from state so reset drops them without waiting for an edge.
    assign mem_req_o   = (state_q == MEM_I) || (state_q == MEM_D);
    assign if_ready_o  = (state_q == RESP_I);
    assign d_ready_o   = (state_q == RESP_D);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i && !if_ready_o) || (d_req_i && !d_ready_o);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (IF stage, read-only) and the data port (MEM stage, read/write).
- Accepts one transaction at a time and holds it until the memory acknowledges it or a watchdog expires.
- Returns data and a one-cycle ready pulse to the requester that owns the transaction.
- Drives a pipeline stall while any request is outstanding. Data has priority; an anti-starvation counter guarantees forward progress for instruction fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants with IF waiting before IF is forced to win (range 1..15)
TIMEOUT, 64, cycles in a MEM_* state without mem_ack_i before an error response (range 2..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
if_req_i  in  1  fetch request, held until if_ready_o
if_addr_i  in  ADDR_W  fetch address
if_ready_o  out  1  one-cycle fetch completion pulse
if_rdata_o  out  DATA_W  fetched instruction, valid while if_ready_o=1, held afterwards
d_req_i  in  1  data request, held until d_ready_o
d_we_i  in  1  1=write, 0=read
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_ready_o  out  1  one-cycle data completion pulse
d_rdata_o  out  DATA_W  load data, updated only on read completion
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion, mem_rdata_i valid in the same cycle
mem_rdata_i  in  DATA_W  memory read data
err_o  out  1  sticky timeout flag, cleared only by reset
stall_o  out  1  pipeline stall

Behaviour:
- One clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values:
  - State is IDLE.
  - All outputs are 0: mem_*, ready, rdata, err_o.
  - starve_cnt and wd_cnt are 0.
- Reset asserted mid-transaction: mem_req_o drops asynchronously, the transaction is abandoned, and no ready pulse is generated.
- FSM states: IDLE, MEM_I, MEM_D, RESP_I, RESP_D.
- IDLE arbitration:
  - Only d_req_i: go to MEM_D.
  - Only if_req_i: go to MEM_I.
  - Both requests: go to MEM_I if starve_cnt==STARVE_MAX, else MEM_D.
  - Neither request: stay in IDLE.
- On the transition into a MEM_* state:
  - Register addr, we and wdata from the winning port (IF: we=0, wdata=0).
  - Clear wd_cnt.
  - mem_req_o=1 from the first MEM_* cycle, so issue latency is 1 cycle after the request is sampled in IDLE.
- While in MEM_*:
  - mem_* outputs are stable.
  - Requester inputs are ignored; changes have no effect.
- MEM_* exit on mem_ack_i=1:
  - Capture mem_rdata_i into the owner's rdata, except data writes, which leave d_rdata_o unchanged.
  - Go to the matching RESP_* state.
  - mem_req_o=0 from the next cycle.
- MEM_* exit on timeout: if wd_cnt reaches TIMEOUT-1 with no ack, go to RESP_*, set err_o=1, load the owner's rdata with 0 (data writes: no rdata change), and drop mem_req_o.
- A late mem_ack_i that arrives outside a MEM_* state is ignored.
- RESP_* state:
  - The owner's ready_o=1 for exactly this cycle; the next state is always IDLE.
  - The requester must drop req or present a new request at the next edge.
  - Requests are not arbitrated in RESP_*.
- Minimum transaction time is 3 cycles (IDLE sample, MEM with same-cycle ack, RESP). Back-to-back throughput is one transaction per 3 cycles.
- starve_cnt, 4 bits, updated at each grant:
  - Data grant with if_req_i=1: increment, saturating at STARVE_MAX.
  - IF grant: clear to 0.
  - Data grant with if_req_i=0: unchanged.
- stall_o = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o), combinational.

Test Plan:
1. Reset, then if_req_i=1, if_addr_i=0x100, and memory acks in the first MEM cycle with 0x00500093 -> mem_req_o high at cycle 1 with mem_addr_o=0x100 and mem_we_o=0; if_ready_o pulses at cycle 2 with if_rdata_o=0x00500093; stall_o=1 for cycles 0-1.
2. Both requests raised in the same cycle (d read 0x200, IF 0x104) -> data served first and d_ready_o pulses; then IF is served; mem_addr_o sequence is 0x200, then 0x104.
3. if_req_i held high while d_req_i re-asserts every IDLE cycle, STARVE_MAX=4 -> exactly 4 data grants, then an IF grant, then starve_cnt=0.
4. Data write, addr 0x40, wdata 0xDEADBEEF, with ack delayed 5 cycles -> mem_we_o=1 and mem_wdata_o stable for 5 cycles; d_ready_o pulses once; d_rdata_o keeps its prior value.
5. Memory never acks, TIMEOUT=64 -> after 64 MEM cycles the owner's ready pulses with rdata=0; err_o=1 and stays 1; an ack arriving afterwards is ignored.
6. rst_i asserted during MEM_D -> mem_req_o=0 asynchronously; no d_ready_o pulse; all outputs are 0; after release, a new request completes normally.
